// File: rtl/data_mem_arbiter_pkg.sv
// data_mem_arbiter_pkg: shared widths and arbiter state encoding
package data_mem_arbiter_pkg;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    typedef enum logic [1:0] {ARB_IDLE, ARB_CORE_RD, ARB_EXT_RD} arb_state_t;
endpackage

// File: rtl/data_mem_arbiter_if.sv
// data_mem_arbiter_if: core, external master, data RAM and perf signals of the arbiter
interface data_mem_arbiter_if
    import data_mem_arbiter_pkg::*;
#(
    parameter int AW = ADDR_W,
    parameter int DW = DATA_W
) ();
    logic          core_rd, core_wr, core_stall;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdata, core_rdata;
    logic          ext_req, ext_we, ext_gnt, ext_rvalid;
    logic [AW-1:0] ext_addr;
    logic [DW-1:0] ext_wdata, ext_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [15:0]   perf_stall, perf_ext;
    modport slave (
        input  core_rd, core_wr, core_addr, core_wdata, ext_req, ext_we, ext_addr, ext_wdata, mem_rdata,
        output core_rdata, core_stall, ext_gnt, ext_rvalid, ext_rdata, mem_addr, mem_we, mem_wdata,
               perf_stall, perf_ext
    );
    modport master (
        output core_rd, core_wr, core_addr, core_wdata, ext_req, ext_we, ext_addr, ext_wdata, mem_rdata,
        input  core_rdata, core_stall, ext_gnt, ext_rvalid, ext_rdata, mem_addr, mem_we, mem_wdata,
               perf_stall, perf_ext
    );
endinterface

// File: rtl/data_mem_arbiter_perf.sv
// arb_perf_counter: 16-bit saturating event counter with enable
module arb_perf_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic        en_i,
    output logic [15:0] cnt_o
);
    logic [15:0] cnt_q;
    always_ff @(posedge clk or negedge reset)
        if (!reset) cnt_q <= '0;
        else if (en_i && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
    assign cnt_o = cnt_q;
endmodule

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: core/ext arbiter for a sync-read data RAM; perf counters built only under ARB_PERF_CNT_EN
module data_mem_arbiter
    import data_mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input logic               clk,
    input logic               reset,
    data_mem_arbiter_if.slave bus
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);
    arb_state_t    state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          core_req, in_crd, ext_win, core_win;
    // Everything is gated by reset so all outputs read 0 while it is held low
    always_comb begin
        in_crd   = state_q == ARB_CORE_RD;
        core_req = bus.core_rd | bus.core_wr;
        ext_win  = reset && bus.ext_req && (!core_req || starve_q == LIMIT || in_crd);
        core_win = reset && !ext_win && core_req && !in_crd;
        state_d  = ext_win && !bus.ext_we ? ARB_EXT_RD : core_win && !bus.core_wr ? ARB_CORE_RD : ARB_IDLE;
        starve_d = !bus.ext_req || ext_win ? '0 : starve_q == LIMIT ? LIMIT : starve_q + SW'(1);
    end
    assign bus.mem_addr   = ext_win ? bus.ext_addr : core_win ? bus.core_addr : '0;
    assign bus.mem_we     = ext_win ? bus.ext_we : core_win && bus.core_wr;
    assign bus.mem_wdata  = ext_win ? bus.ext_wdata : core_win ? bus.core_wdata : '0;
    assign bus.core_stall = reset && core_req && !in_crd && !(core_win && bus.core_wr);
    assign bus.core_rdata = in_crd ? bus.mem_rdata : '0;
    assign bus.ext_gnt    = ext_win;
    assign bus.ext_rvalid = state_q == ARB_EXT_RD;
    assign bus.ext_rdata  = state_q == ARB_EXT_RD ? bus.mem_rdata : '0;
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state_q  <= ARB_IDLE;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
`ifdef ARB_PERF_CNT_EN
    arb_perf_counter u_stall_cnt (.clk(clk), .reset(reset), .en_i(bus.core_stall), .cnt_o(bus.perf_stall));
    arb_perf_counter u_ext_cnt (.clk(clk), .reset(reset), .en_i(bus.ext_gnt), .cnt_o(bus.perf_ext));
`else
    assign bus.perf_stall = '0;
    assign bus.perf_ext   = '0;
`endif
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed table, reset/starvation sequences and random traffic against a reference model
module tb_data_mem_arbiter;
    typedef struct {
        logic       crd, cwr;
        logic [7:0] caddr, cwdata;
        logic       ereq, ewe;
        logic [7:0] eaddr, ewdata;
        logic       stall, gnt, rv, we;
        logic [7:0] maddr, mwdata;
        logic       cv;
        logic [7:0] crdata, erdata;
    } vec_t;

    logic clk = 0, reset = 0;
    int errors = 0, checks = 0;
    int exp_ps = 0, exp_pe = 0;
    logic [7:0] ram [256];
    logic [7:0] shadow [256];
    vec_t tbl [21];
    vec_t idle_v;

    data_mem_arbiter_if bus ();
    data_mem_arbiter #(.STARVE_LIMIT(4)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= ram[bus.mem_addr];
    end

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic chk_perf(string n);
`ifdef ARB_PERF_CNT_EN
        chk({n, ".perf_stall"}, 32'(bus.perf_stall), exp_ps);
        chk({n, ".perf_ext"}, 32'(bus.perf_ext), exp_pe);
`else
        chk({n, ".perf_stall"}, 32'(bus.perf_stall), 0);
        chk({n, ".perf_ext"}, 32'(bus.perf_ext), 0);
`endif
    endtask

    task automatic drive(logic crd, logic cwr, logic [7:0] ca, logic [7:0] cw,
                         logic ereq, logic ewe, logic [7:0] ea, logic [7:0] ew);
        bus.core_rd = crd; bus.core_wr = cwr; bus.core_addr = ca; bus.core_wdata = cw;
        bus.ext_req = ereq; bus.ext_we = ewe; bus.ext_addr = ea; bus.ext_wdata = ew;
    endtask

    task automatic apply(vec_t v, string tag);
        @(negedge clk);
        drive(v.crd, v.cwr, v.caddr, v.cwdata, v.ereq, v.ewe, v.eaddr, v.ewdata);
        #2;
        chk({tag, ".stall"}, bus.core_stall, v.stall);
        chk({tag, ".gnt"}, bus.ext_gnt, v.gnt);
        chk({tag, ".rvalid"}, bus.ext_rvalid, v.rv);
        chk({tag, ".mem_we"}, bus.mem_we, v.we);
        chk({tag, ".mem_addr"}, bus.mem_addr, v.maddr);
        if (v.we) chk({tag, ".mem_wdata"}, bus.mem_wdata, v.mwdata);
        if (v.cv) chk({tag, ".core_rdata"}, bus.core_rdata, v.crdata);
        if (v.rv) chk({tag, ".ext_rdata"}, bus.ext_rdata, v.erdata);
        exp_ps += int'(v.stall);
        exp_pe += int'(v.gnt);
    endtask

    function automatic vec_t starve_v(int i);
        vec_t v = '{default: 0};
        v.cwr = 1; v.caddr = 8'h70 + 8'(i); v.cwdata = 8'(i);
        v.ereq = 1; v.eaddr = 8'h20;
        v.stall = i == 4; v.gnt = i == 4; v.we = i != 4;
        v.maddr = i == 4 ? 8'h20 : v.caddr; v.mwdata = v.cwdata;
        return v;
    endfunction

    initial begin
        idle_v = '{default: 0};
        //          crd cwr caddr cwd   ereq ewe eaddr ewd   stl gnt rv we maddr mwd   cv crd   erd
        tbl[0]  = '{1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 8'h10, 8'h00, 0, 8'h00, 8'h00};
        tbl[1]  = '{1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00, 1, 8'hA5, 8'h00};
        tbl[2]  = '{0, 1, 8'h20, 8'h3C, 0, 0, 8'h00, 8'h00, 0, 0, 0, 1, 8'h20, 8'h3C, 0, 8'h00, 8'h00};
        tbl[3]  = '{0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00};
        tbl[4]  = '{0, 0, 8'h00, 8'h00, 1, 0, 8'h20, 8'h00, 0, 1, 0, 0, 8'h20, 8'h00, 0, 8'h00, 8'h00};
        tbl[5]  = '{0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 1, 0, 8'h00, 8'h00, 0, 8'h00, 8'h3C};
        tbl[6]  = '{1, 0, 8'h30, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 8'h30, 8'h00, 0, 8'h00, 8'h00};
        tbl[7]  = '{1, 0, 8'h30, 8'h00, 1, 0, 8'h10, 8'h00, 0, 1, 0, 0, 8'h10, 8'h00, 1, 8'h77, 8'h00};
        tbl[8]  = '{0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 1, 0, 8'h00, 8'h00, 0, 8'h00, 8'hA5};
        tbl[9]  = '{0, 1, 8'h40, 8'h11, 1, 0, 8'h20, 8'h00, 0, 0, 0, 1, 8'h40, 8'h11, 0, 8'h00, 8'h00};
        tbl[10] = '{0, 1, 8'h41, 8'h12, 1, 0, 8'h20, 8'h00, 0, 0, 0, 1, 8'h41, 8'h12, 0, 8'h00, 8'h00};
        tbl[11] = '{0, 1, 8'h42, 8'h13, 1, 0, 8'h20, 8'h00, 0, 0, 0, 1, 8'h42, 8'h13, 0, 8'h00, 8'h00};
        tbl[12] = '{0, 1, 8'h43, 8'h14, 1, 0, 8'h20, 8'h00, 0, 0, 0, 1, 8'h43, 8'h14, 0, 8'h00, 8'h00};
        tbl[13] = '{0, 1, 8'h44, 8'h15, 1, 0, 8'h20, 8'h00, 1, 1, 0, 0, 8'h20, 8'h00, 0, 8'h00, 8'h00};
        tbl[14] = '{0, 1, 8'h44, 8'h15, 0, 0, 8'h00, 8'h00, 0, 0, 1, 1, 8'h44, 8'h15, 0, 8'h00, 8'h3C};
        tbl[15] = '{1, 0, 8'h43, 8'h00, 1, 1, 8'h50, 8'h9A, 1, 0, 0, 0, 8'h43, 8'h00, 0, 8'h00, 8'h00};
        tbl[16] = '{1, 0, 8'h43, 8'h00, 1, 1, 8'h50, 8'h9A, 0, 1, 0, 1, 8'h50, 8'h9A, 1, 8'h14, 8'h00};
        tbl[17] = '{1, 1, 8'h60, 8'h5A, 0, 0, 8'h00, 8'h00, 0, 0, 0, 1, 8'h60, 8'h5A, 0, 8'h00, 8'h00};
        tbl[18] = '{0, 0, 8'h00, 8'h00, 1, 0, 8'h50, 8'h00, 0, 1, 0, 0, 8'h50, 8'h00, 0, 8'h00, 8'h00};
        tbl[19] = '{0, 0, 8'h00, 8'h00, 1, 0, 8'h60, 8'h00, 0, 1, 1, 0, 8'h60, 8'h00, 0, 8'h00, 8'h9A};
        tbl[20] = '{0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 1, 0, 8'h00, 8'h00, 0, 8'h00, 8'h5A};
        for (int i = 0; i < 256; i++) ram[i] = 8'h00;
        ram[8'h10] = 8'hA5;
        ram[8'h30] = 8'h77;

        // reset held with active requests: every output must stay 0
        drive(1, 0, 8'h10, 8'h00, 1, 1, 8'h20, 8'h55);
        #3;
        chk("rst0.stall", bus.core_stall, 0);
        chk("rst0.gnt", bus.ext_gnt, 0);
        chk("rst0.rvalid", bus.ext_rvalid, 0);
        chk("rst0.mem_we", bus.mem_we, 0);
        chk("rst0.mem_addr", bus.mem_addr, 0);
        chk("rst0.mem_wdata", bus.mem_wdata, 0);
        chk_perf("rst0");
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1;

        for (int i = 0; i < 21; i++) apply(tbl[i], $sformatf("tbl%0d", i));
        apply(idle_v, "tbl.idle");
        chk_perf("tbl");

        // async reset in the middle of an ext read: rvalid dropped, nothing returns afterwards
        apply('{0, 0, 8'h00, 8'h00, 1, 0, 8'h10, 8'h00, 0, 1, 0, 0, 8'h10, 8'h00, 0, 8'h00, 8'h00}, "rst_a.issue");
        @(negedge clk);
        drive(1, 0, 8'h10, 8'h00, 1, 0, 8'h20, 8'h00);
        #1 reset = 0;
        #1;
        chk("rst_a.rvalid", bus.ext_rvalid, 0);
        chk("rst_a.ext_rdata", bus.ext_rdata, 0);
        chk("rst_a.stall", bus.core_stall, 0);
        chk("rst_a.gnt", bus.ext_gnt, 0);
        chk("rst_a.mem_addr", bus.mem_addr, 0);
        chk("rst_a.core_rdata", bus.core_rdata, 0);
        exp_ps = 0; exp_pe = 0;
        chk_perf("rst_a.low");
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1;
        #2 chk("rst_a.release_rvalid", bus.ext_rvalid, 0);
        apply(idle_v, "rst_a.idle");

        // partially built starvation must be cleared by reset: grant again needs the full 5 cycles
        for (int i = 0; i < 3; i++) apply(starve_v(i), "starve.pre");
        @(negedge clk);
        reset = 0;
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1;
        exp_ps = 0; exp_pe = 0;
        for (int i = 0; i < 5; i++) apply(starve_v(i), $sformatf("starve.post%0d", i));
        apply('{0, 1, 8'h74, 8'h04, 0, 0, 8'h00, 8'h00, 0, 0, 1, 1, 8'h74, 8'h04, 0, 8'h00, 8'h3C}, "starve.ret");
        chk_perf("starve");

        // random traffic against the reference model
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        reset = 0;
        @(negedge clk);
        reset = 1;
        exp_ps = 0; exp_pe = 0;
        shadow = ram;
        begin
            logic       c_rd, c_wr, e_req, e_we, m_crd, m_erd;
            logic [7:0] c_a, c_d, e_a, e_d, m_cv, m_ev;
            int         starve;
            c_rd = 0; c_wr = 0; e_req = 0; e_we = 0; m_crd = 0; m_erd = 0;
            c_a = 0; c_d = 0; e_a = 0; e_d = 0; m_cv = 0; m_ev = 0; starve = 0;
            for (int n = 0; n < 400; n++) begin
                logic       creq, ew, cw, stall, we;
                logic [7:0] ma, md;
                int         r;
                @(negedge clk);
                drive(c_rd, c_wr, c_a, c_d, e_req, e_we, e_a, e_d);
                creq  = c_rd | c_wr;
                ew    = e_req && (!creq || starve == 4 || m_crd);
                cw    = !ew && creq && !m_crd;
                stall = creq && !m_crd && !(cw && c_wr);
                we    = ew ? e_we : cw && c_wr;
                ma    = ew ? e_a : cw ? c_a : 8'h00;
                md    = ew ? e_d : c_d;
                #2;
                chk("rnd.stall", bus.core_stall, stall);
                chk("rnd.gnt", bus.ext_gnt, ew);
                chk("rnd.rvalid", bus.ext_rvalid, m_erd);
                chk("rnd.mem_we", bus.mem_we, we);
                chk("rnd.mem_addr", bus.mem_addr, ma);
                if (we) chk("rnd.mem_wdata", bus.mem_wdata, md);
                if (m_crd) chk("rnd.core_rdata", bus.core_rdata, m_cv);
                if (m_erd) chk("rnd.ext_rdata", bus.ext_rdata, m_ev);
                exp_ps += int'(stall);
                exp_pe += int'(ew);
                m_crd = cw && !c_wr; m_cv = shadow[c_a];
                m_erd = ew && !e_we; m_ev = shadow[e_a];
                if (ew && e_we) shadow[e_a] = e_d;
                if (cw && c_wr) shadow[c_a] = c_d;
                starve = (!e_req || ew) ? 0 : (starve < 4 ? starve + 1 : 4);
                if (!stall) begin
                    r = int'($urandom_range(0, 3));
                    c_rd = (r & 1) != 0; c_wr = (r & 2) != 0;
                    c_a = 8'($urandom_range(0, 15)); c_d = 8'($urandom);
                end
                if (!e_req || ew) begin
                    e_req = $urandom_range(0, 1) == 1; e_we = $urandom_range(0, 1) == 1;
                    e_a = 8'($urandom_range(0, 15)); e_d = 8'($urandom);
                end
            end
        end
        @(negedge clk);
        #2 chk_perf("rnd");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
